// File: rtl/ex_result_buffer_pkg.sv
// Shared types for the execute back end: common scalar widths and the
// pipeline entry carried from execute to memory.
package common;
  localparam int unsigned XLEN = 64;
  typedef logic [XLEN-1:0] word_t;
  typedef logic [XLEN-1:0] addr_t;
  typedef logic [4:0]      creg_addr_t;
endpackage

package pipes;
  import common::*;
  typedef struct packed {
    word_t      result;
    addr_t      pc;
    creg_addr_t rd;
    logic       wen;
  } ex_res_t;
endpackage

// File: rtl/ex_result_buffer_word_sext.sv
// W-form result sign extension from bit 31; also used by the decode-side
// immediate path.
module word_sext
  import common::*;
(
  input  logic  is_word,
  input  word_t value,
  output word_t result
);
  always_comb begin
    result = is_word ? {{(XLEN-32){value[31]}}, value[31:0]} : value;
  end
endmodule

// File: rtl/ex_result_buffer.sv
// Execute-stage result buffer: normalises ALU results and holds them in a
// 2-entry skid FIFO. Optional forwarding taps under EXRES_BYPASS_EN.
module ex_result_buffer
  import pipes::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned XLEN  = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_aluout,
  input  logic            in_is_word,
  input  logic [XLEN-1:0] in_pc,
  input  logic [4:0]      in_rd,
  input  logic            in_wen,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rd,
  output logic            out_wen
`ifdef EXRES_BYPASS_EN
  ,
  output logic            fwd_valid,
  output logic [4:0]      fwd_rd,
  output logic [XLEN-1:0] fwd_data
`endif
);
  if (DEPTH != 2) begin : g_bad_depth
    $error("ex_result_buffer: DEPTH must be 2");
  end
  if (XLEN != common::XLEN) begin : g_bad_xlen
    $error("ex_result_buffer: XLEN must match common::XLEN");
  end

  ex_res_t              entries [DEPTH];
  ex_res_t              wr_entry;
  ex_res_t              head;
  logic                 rptr;
  logic                 wptr;
  logic [1:0]           count;
  logic                 push;
  logic                 pop;
  common::word_t        sext_result;

  word_sext u_sext (
    .is_word (in_is_word),
    .value   (in_aluout),
    .result  (sext_result)
  );

  // Ready depends only on occupancy so out_ready never reaches in_ready.
  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    wr_entry        = '0;
    wr_entry.result = sext_result;
    wr_entry.pc     = in_pc;
    wr_entry.rd     = in_rd;
    wr_entry.wen    = in_wen & (in_rd != 5'd0);
  end

  always_comb begin
    head = '0;
    if (out_valid) head = entries[rptr];
  end

  assign out_result = head.result;
  assign out_pc     = head.pc;
  assign out_rd     = head.rd;
  assign out_wen    = head.wen;

`ifdef EXRES_BYPASS_EN
  assign fwd_valid = out_valid & head.wen;
  assign fwd_rd    = head.rd;
  assign fwd_data  = head.result;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      rptr  <= 1'b0;
      wptr  <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) entries[i] <= '0;
    end else if (flush) begin
      // Entry data is left in place; count=0 masks it from the outputs.
      count <= '0;
      rptr  <= 1'b0;
      wptr  <= 1'b0;
    end else begin
      if (push) begin
        entries[wptr] <= wr_entry;
        wptr          <= ~wptr;
      end
      if (pop) rptr <= ~rptr;
      if (push && !pop)      count <= count + 2'd1;
      else if (pop && !push) count <= count - 2'd1;
    end
  end
endmodule

// File: tb/tb_ex_result_buffer.sv
// Randomised and directed bench for ex_result_buffer against a queue model.
module tb_ex_result_buffer;
  typedef struct {
    logic [63:0] result;
    logic [63:0] pc;
    logic [4:0]  rd;
    logic        wen;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, in_is_word, in_wen;
  logic [63:0] in_aluout, in_pc;
  logic [4:0]  in_rd;
  logic        out_valid, out_ready, out_wen;
  logic [63:0] out_result, out_pc;
  logic [4:0]  out_rd;
`ifdef EXRES_BYPASS_EN
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [63:0] fwd_data;
`endif

  int unsigned checks = 0;
  int unsigned errors = 0;
  ent_t        q[$];
  logic [63:0] popped_pcs[$];
  bit          armed = 0;
  int unsigned dut_pops = 0;

  ex_result_buffer #(.DEPTH(2), .XLEN(64)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_aluout(in_aluout),
    .in_is_word(in_is_word), .in_pc(in_pc), .in_rd(in_rd), .in_wen(in_wen),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_pc(out_pc), .out_rd(out_rd), .out_wen(out_wen)
`ifdef EXRES_BYPASS_EN
    , .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic ent_t model_entry();
    ent_t e;
    e.result = in_is_word ? 64'($signed(in_aluout[31:0])) : in_aluout;
    e.pc     = in_pc;
    e.rd     = in_rd;
    e.wen    = in_wen && (in_rd != 0);
    return e;
  endfunction

  task automatic check_outputs();
    ent_t h;
    h = '{result: 64'd0, pc: 64'd0, rd: 5'd0, wen: 1'b0};
    if (q.size() > 0) h = q[0];
    check("out_valid", 64'(out_valid), 64'(q.size() != 0));
    check("in_ready", 64'(in_ready), 64'(q.size() != 2));
    check("out_result", out_result, h.result);
    check("out_pc", out_pc, h.pc);
    check("out_rd", 64'(out_rd), 64'(h.rd));
    check("out_wen", 64'(out_wen), 64'(h.wen));
`ifdef EXRES_BYPASS_EN
    check("fwd_valid", 64'(fwd_valid), 64'(q.size() != 0 && h.wen));
    check("fwd_rd", 64'(fwd_rd), 64'(h.rd));
    check("fwd_data", fwd_data, h.result);
`endif
  endtask

  // One clock: compare outputs, advance model with the applied inputs.
  task automatic tick();
    bit   do_push, do_pop;
    ent_t e;
    if (armed) check_outputs();
    if (out_valid && out_ready) dut_pops++;
    do_pop  = (q.size() > 0) && out_ready;
    do_push = in_valid && (q.size() < 2);
    e = model_entry();
    @(posedge clk);
    if (reset || flush) q.delete();
    else begin
      if (do_pop) popped_pcs.push_back(q.pop_front().pc);
      if (do_push) q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic set_in(input logic v, input logic [63:0] pc, input logic [63:0] alu,
                        input logic w, input logic [4:0] rd, input logic wen);
    in_valid = v; in_pc = pc; in_aluout = alu; in_is_word = w; in_rd = rd; in_wen = wen;
  endtask

  initial begin
    reset = 1; flush = 0; out_ready = 0;
    set_in(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    tick();
    armed = 1;
    tick();
    reset = 0;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);

    // Sign extension
    out_ready = 1;
    set_in(1, 64'h10, 64'h0000_0000_8000_0000, 1, 5'd3, 1); tick();
    set_in(1, 64'h14, 64'h0000_0000_8000_0000, 0, 5'd3, 1);
    check("sext_word", out_result, 64'hFFFF_FFFF_8000_0000);
    tick();
    set_in(0, 0, 0, 0, 0, 0);
    check("sext_dword", out_result, 64'h0000_0000_8000_0000);
    tick();

    // x0 suppression
    set_in(1, 64'h20, 64'h1234, 0, 5'd0, 1); tick();
    set_in(1, 64'h24, 64'h5678, 0, 5'd5, 1);
    check("x0_wen", 64'(out_wen), 64'd0);
    tick();
    set_in(0, 0, 0, 0, 0, 0);
    check("x5_wen", 64'(out_wen), 64'd1);
    check("x5_rd", 64'(out_rd), 64'd5);
    tick();

    // Back-pressure ordering
    out_ready = 0;
    popped_pcs.delete();
    set_in(1, 64'h100, 64'hA, 0, 5'd1, 1); tick();
    set_in(1, 64'h104, 64'hB, 0, 5'd2, 1); tick();
    set_in(1, 64'h108, 64'hC, 0, 5'd3, 1);
    check("full_in_ready", 64'(in_ready), 64'd0);
    tick(); tick();
    out_ready = 1;
    check("bp_head", out_pc, 64'h100);
    tick();
    check("bp_refill_ready", 64'(in_ready), 64'd1);
    tick();
    set_in(0, 0, 0, 0, 0, 0);
    repeat (3) tick();
    check("bp_npop", 64'(popped_pcs.size()), 64'd3);
    if (popped_pcs.size() == 3) begin
      check("bp_order0", popped_pcs[0], 64'h100);
      check("bp_order1", popped_pcs[1], 64'h104);
      check("bp_order2", popped_pcs[2], 64'h108);
    end

    // Streaming
    dut_pops = 0;
    for (int i = 0; i < 100; i++) begin
      set_in(1, 64'h1000 + 64'(i) * 4, $urandom, 1'($urandom), 5'($urandom), 1'($urandom));
      tick();
    end
    set_in(0, 0, 0, 0, 0, 0);
    check("stream_pops", 64'(dut_pops), 64'd99);
    tick();

    // Flush while full with a same-cycle input
    out_ready = 0;
    set_in(1, 64'h300, 64'h1, 0, 5'd1, 1); tick();
    set_in(1, 64'h304, 64'h2, 0, 5'd2, 1); tick();
    flush = 1;
    set_in(1, 64'h200, 64'h3, 0, 5'd3, 1); tick();
    flush = 0;
    set_in(0, 0, 0, 0, 0, 0);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    out_ready = 1;
    repeat (3) tick();

    // Reset mid-stream
    set_in(1, 64'h400, 64'h44, 0, 5'd4, 1); out_ready = 0; tick();
    set_in(0, 0, 0, 0, 0, 0);
    reset = 1; tick(); reset = 0;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_result", out_result, 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    set_in(1, 64'h404, 64'h55, 0, 5'd6, 1); tick();
    set_in(0, 0, 0, 0, 0, 0);
    check("rst_next_pc", out_pc, 64'h404);
    tick();

    // Random traffic honouring the upstream hold rule
    for (int i = 0; i < 400; i++) begin
      bit held;
      held = in_valid && (q.size() == 2);
      if (!held)
        set_in(1'($urandom_range(0, 3) != 0), {$urandom, $urandom}, {$urandom, $urandom},
               1'($urandom), 5'($urandom), 1'($urandom));
      out_ready = 1'($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 29) == 0);
      reset     = ($urandom_range(0, 59) == 0);
      tick();
    end
    reset = 0; flush = 0;
    set_in(0, 0, 0, 0, 0, 0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ex_result_buffer.md
Name: ex_result_buffer

Overview:
- Execute-stage back end that captures each ALU result and normalises it for the memory stage.
- Sign-extends RV64 W-op results from bit 31; the ALU produces these zero-extended.
- Forces writes to x0 off.
- Holds results in a 2-entry skid FIFO with valid/ready handshakes on both sides, so memory-stage stalls do not combinationally stall the ALU path.

Parameters:
DEPTH, 2, number of buffer entries; fixed at 2, any other value is a compile-time error.
XLEN, 64, data/PC width.

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
flush  in  1  discard all buffered entries (branch mispredict / trap)
in_valid  in  1  upstream holds a valid result
in_ready  out  1  buffer can accept this cycle
in_aluout  in  64  raw ALU result
in_is_word  in  1  result comes from a W-form op (ADDW, SLLW, SRLW, SRAW, ...)
in_pc  in  64  instruction PC
in_rd  in  5  destination register
in_wen  in  1  register write enable
out_valid  out  1  head entry valid
out_ready  in  1  memory stage accepts head
out_result  out  64  normalised result
out_pc  out  64  head PC
out_rd  out  5  head destination
out_wen  out  1  head write enable

Behaviour:
- State: two entry registers, 1-bit read pointer, 1-bit write pointer, 2-bit count (0..2).
- Reset is synchronous. On the cycle after reset is asserted: count=0, pointers=0, out_valid=0, entry contents cleared to 0.
- Outputs: out_result/out_pc/out_rd/out_wen drive the head entry when count>0, and all-zero when count=0.
- in_ready = (count != 2). It is a function of registered state only, with no combinational path from out_ready.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- Push write normalisation:
  - result = in_is_word ? {{32{in_aluout[31]}}, in_aluout[31:0]} : in_aluout.
  - wen = in_wen & (in_rd != 0).
- Count update: push only gives count+1; pop only gives count-1; push and pop together leave count unchanged, with both pointers advancing.
- Latency: minimum 1 cycle, input accepted at edge N is visible at outputs after edge N. There is no same-cycle pass-through.
- Empty: out_valid=0, and out_ready is ignored.
- Full: in_ready=0. Because push is impossible, a pop alone drops count to 1 and in_ready rises the following cycle.
- Pointers wrap modulo 2.
- Flush has priority over push and pop. At the edge: count=0, pointers=0, and any same-cycle input is dropped; entry data is not cleared.
- reset has priority over flush.
- Handshake rule: upstream must hold in_* stable while in_valid & !in_ready. The buffer holds out_* stable while out_valid & !out_ready.
- No X propagation: every register has a defined reset value.

Optional Feature:
- Macro: EXRES_BYPASS_EN.
- When defined, three extra output ports are added:
  - fwd_valid (1) = out_valid & out_wen.
  - fwd_rd (5) = out_rd.
  - fwd_data (64) = out_result.
- These feed the decode-stage forwarding mux, and are zero when empty.
- When undefined, the ports do not exist and there is no extra logic.

Decomposition:
- Package pipes gains typedef ex_res_t: struct {word_t result; addr_t pc; creg_addr_t rd; logic wen;}. The buffer stores ex_res_t entries.
- Package common supplies word_t and XLEN.
- One sub-module, word_sext: combinational W-result sign extension, in {is_word, word_t} out word_t. The decode-side immediate path reuses it.

Test Plan:
- Sign extension: push in_aluout=0x0000_0000_8000_0000, in_is_word=1 with out_ready=1 -> next cycle out_valid=1, out_result=0xFFFF_FFFF_8000_0000. The same value with is_word=0 -> 0x0000_0000_8000_0000.
- x0 suppression: push rd=0, wen=1 -> out_wen=0. Push rd=5, wen=1 -> out_wen=1, out_rd=5.
- Back-pressure ordering:
  - Hold out_ready=0 and push A (pc=0x100) then B (pc=0x104) -> count=2, in_ready=0, and C is held.
  - Raise out_ready -> outputs in order 0x100, 0x104, 0x108, with no loss and no duplication.
- Streaming: continuous in_valid=1 and out_ready=1 for 100 cycles with incrementing pc -> one result per cycle, in_ready stays 1, output order matches input.
- Flush: count=2, assert flush together with in_valid=1 (pc=0x200) -> next cycle out_valid=0, count=0, and 0x200 never appears at the output.
- Reset mid-stream: count=1, assert reset for 1 cycle -> out_valid=0, out_result=0, in_ready=1. The next push appears normally.
